// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
// Optional LU bypass is selected by the WB_BYPASS_EN macro.
package rf_wb_arbiter_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;

    localparam logic [4:0] REG_RA   = 5'd31;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_PIPE,
        GNT_POP,
        GNT_BYP
    } grant_e;

endpackage

// File: rtl/wb_result_fifo.sv
// Small FIFO holding LU results until the write port is free.
// Caller guarantees no push when full and no pop when empty.
module wb_result_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    import rf_wb_arbiter_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointer overflow is the wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: WB stage vs. queued LU results.
// Define WB_BYPASS_EN to let LU results skip an empty FIFO.
module rf_wb_arbiter #(
    parameter int DATA_W     = rf_wb_arbiter_pkg::DATA_W,
    parameter int REG_AW     = rf_wb_arbiter_pkg::REG_AW,
    parameter int Q_DEPTH    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pipe_we,
    input  logic [REG_AW-1:0] pipe_dest,
    input  logic [DATA_W-1:0] pipe_wdata,
    input  logic              lu_issue,
    input  logic [REG_AW-1:0] lu_issue_dest,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [REG_AW-1:0] lu_dest,
    input  logic [DATA_W-1:0] lu_data,
    input  logic [REG_AW-1:0] rd_addr_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic              busy_a,
    output logic              busy_b,
    output logic              stall_req,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);
    import rf_wb_arbiter_pkg::*;

    localparam int SW   = $clog2(STARVE_MAX + 1);
    localparam int EW   = REG_AW + DATA_W;
    localparam int NREG = 1 << REG_AW;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [EW-1:0]     head;
    logic [REG_AW-1:0] head_dest;
    logic [DATA_W-1:0] head_data;
    grant_e            grant;
    logic [REG_AW-1:0] sel_dest;
    logic [DATA_W-1:0] sel_data;
    logic              clr;

    logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic              rf_we_q, rf_we_d;
    logic [REG_AW-1:0] rf_waddr_q;
    logic [DATA_W-1:0] rf_wdata_q;

    assign {head_dest, head_data} = head;

    assign lu_ready  = !full;
    assign stall_req = (starve_cnt_q == SW'(STARVE_MAX)) && !empty;
    assign busy_a    = busy_q[rd_addr_a];
    assign busy_b    = busy_q[rd_addr_b];

    always_comb begin
        grant = GNT_NONE;
        if (stall_req)    grant = GNT_POP;
        else if (pipe_we) grant = GNT_PIPE;
        else if (!empty)  grant = GNT_POP;
`ifdef WB_BYPASS_EN
        else if (lu_valid) grant = GNT_BYP;
`endif
    end

    assign pop  = (grant == GNT_POP);
    assign clr  = pop || (grant == GNT_BYP);
    assign push = lu_valid && !full && (grant != GNT_BYP);

    always_comb begin
        sel_dest = '0;
        sel_data = '0;
        unique case (grant)
            GNT_PIPE: begin
                sel_dest = pipe_dest;
                sel_data = pipe_wdata;
            end
            GNT_POP: begin
                sel_dest = head_dest;
                sel_data = head_data;
            end
            GNT_BYP: begin
                sel_dest = lu_dest;
                sel_data = lu_data;
            end
            GNT_NONE: ;
        endcase
    end

    // reg 0 writes are dropped but still retire their busy bit
    assign rf_we_d = (grant != GNT_NONE) && (sel_dest != REG_ZERO);

    always_comb begin
        busy_d = busy_q;
        if (clr)      busy_d[sel_dest] = 1'b0;
        if (lu_issue) busy_d[lu_issue_dest] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (pop || empty)
            starve_cnt_d = '0;
        else if (starve_cnt_q != SW'(STARVE_MAX))
            starve_cnt_d = starve_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            starve_cnt_q <= '0;
            busy_q       <= '0;
        end else begin
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= sel_dest;
            rf_wdata_q   <= sel_data;
            starve_cnt_q <= starve_cnt_d;
            busy_q       <= busy_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    wb_result_fifo #(
        .W     (EW),
        .DEPTH (Q_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i ({lu_dest, lu_data}),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter; expected RF writes go through a queue.
// Build with WB_BYPASS_EN defined to exercise the bypass path.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        pipe_we;
    logic [4:0]  pipe_dest;
    logic [31:0] pipe_wdata;
    logic        lu_issue;
    logic [4:0]  lu_issue_dest;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_dest;
    logic [31:0] lu_data;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic        busy_a;
    logic        busy_b;
    logic        stall_req;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  n_chk;
    int  n_fail;

    rf_wb_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pipe_we       (pipe_we),
        .pipe_dest     (pipe_dest),
        .pipe_wdata    (pipe_wdata),
        .lu_issue      (lu_issue),
        .lu_issue_dest (lu_issue_dest),
        .lu_valid      (lu_valid),
        .lu_ready      (lu_ready),
        .lu_dest       (lu_dest),
        .lu_data       (lu_data),
        .rd_addr_a     (rd_addr_a),
        .rd_addr_b     (rd_addr_b),
        .busy_a        (busy_a),
        .busy_b        (busy_b),
        .stall_req     (stall_req),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pipe_we       = 1'b0;
        pipe_dest     = '0;
        pipe_wdata    = '0;
        lu_issue      = 1'b0;
        lu_issue_dest = '0;
        lu_valid      = 1'b0;
        lu_dest       = '0;
        lu_data       = '0;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // monitor: every RF write must match the next queued expectation
    always @(negedge clk) begin
        wr_t e;
        if (rst_n === 1'b1 && rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %0h, required none",
                         rf_waddr, rf_wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(rf_waddr), 32'(e.a));
                check("wr_data", rf_wdata, e.d);
            end
        end
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        idle();
        rd_addr_a = '0;
        rd_addr_b = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_we", 32'(rf_we), 32'd0);
        check("rst_waddr", 32'(rf_waddr), 32'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        check("rst_ready", 32'(lu_ready), 32'd1);
        check("rst_stall", 32'(stall_req), 32'd0);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // pipe beats LU in the same cycle; LU follows on the idle cycle
        pipe_we = 1'b1; pipe_dest = 5'd8; pipe_wdata = 32'hAAAA;
        lu_valid = 1'b1; lu_dest = 5'd9; lu_data = 32'h5555;
        expect_wr(5'd8, 32'hAAAA);
        expect_wr(5'd9, 32'h5555);
        tick();
        idle();
        check("prio_we", 32'(rf_we), 32'd1);
        check("prio_waddr", 32'(rf_waddr), 32'd8);
        tick();
        check("prio_lu_waddr", 32'(rf_waddr), 32'd9);
        tick();
        check("prio_idle_we", 32'(rf_we), 32'd0);

        // scoreboard set / clear
        rd_addr_a = 5'd12;
        rd_addr_b = 5'd12;
        lu_issue = 1'b1; lu_issue_dest = 5'd12;
        check("sb_no_lookahead", 32'(busy_a), 32'd0);
        tick();
        lu_issue = 1'b0;
        check("sb_busy_a", 32'(busy_a), 32'd1);
        tick();
        check("sb_busy_hold", 32'(busy_a), 32'd1);
        lu_valid = 1'b1; lu_dest = 5'd12; lu_data = 32'h1212;
        expect_wr(5'd12, 32'h1212);
        tick();
        lu_valid = 1'b0;
`ifndef WB_BYPASS_EN
        check("sb_queued_busy", 32'(busy_a), 32'd1);
        check("sb_queued_we", 32'(rf_we), 32'd0);
        tick();
`endif
        check("sb_ret_waddr", 32'(rf_waddr), 32'd12);
        check("sb_cleared", 32'(busy_a), 32'd0);

        // set and clear of reg 12 in the same cycle: set wins
        lu_issue = 1'b1; lu_issue_dest = 5'd12;
        tick();
        lu_issue = 1'b0;
        lu_valid = 1'b1; lu_dest = 5'd12; lu_data = 32'h3434;
        expect_wr(5'd12, 32'h3434);
`ifdef WB_BYPASS_EN
        lu_issue = 1'b1;
        tick();
        lu_issue = 1'b0;
        lu_valid = 1'b0;
`else
        tick();
        lu_valid = 1'b0;
        lu_issue = 1'b1;
        tick();
        lu_issue = 1'b0;
`endif
        check("sb_setwins_waddr", 32'(rf_waddr), 32'd12);
        check("sb_setwins_a", 32'(busy_a), 32'd1);
        check("sb_setwins_b", 32'(busy_b), 32'd1);
        rd_addr_b = 5'd0;
        #1;
        check("sb_reg0", 32'(busy_b), 32'd0);
        tick();

        // starvation: one queued entry behind continuous pipe writes
        expect_wr(5'd5, 32'h100);
        expect_wr(5'd6, 32'h101);
        expect_wr(5'd7, 32'h102);
        expect_wr(5'd8, 32'h103);
        expect_wr(5'd20, 32'h2020);
        expect_wr(5'd9, 32'h104);
        for (int c = 0; c < 6; c++) begin
            automatic int idx = (c < 5) ? c : 4;
            pipe_we    = 1'b1;
            pipe_dest  = 5'(5 + idx);
            pipe_wdata = 32'h100 + 32'(idx);
            lu_valid   = (c == 0);
            lu_dest    = 5'd20;
            lu_data    = 32'h2020;
            check($sformatf("starve_stall_c%0d", c), 32'(stall_req),
                  32'(c == 4));
            tick();
            if (c == 4) check("starve_pop_waddr", 32'(rf_waddr), 32'd20);
        end
        idle();
        tick();

        // full FIFO with a held LU result
        expect_wr(5'd10, 32'h200);
        expect_wr(5'd11, 32'h201);
        expect_wr(5'd12, 32'h202);
        expect_wr(5'd13, 32'h203);
        expect_wr(5'd21, 32'h2121);
        expect_wr(5'd14, 32'h204);
        expect_wr(5'd22, 32'h2222);
        expect_wr(5'd23, 32'h2323);
        for (int c = 0; c < 8; c++) begin
            automatic int idx = (c < 5) ? c : 4;
            pipe_we    = (c <= 5);
            pipe_dest  = 5'(10 + idx);
            pipe_wdata = 32'h200 + 32'(idx);
            lu_valid   = (c <= 5);
            lu_dest    = (c == 0) ? 5'd21 : (c == 1) ? 5'd22 : 5'd23;
            lu_data    = (c == 0) ? 32'h2121 :
                         (c == 1) ? 32'h2222 : 32'h2323;
            if (c <= 5)
                check($sformatf("full_ready_c%0d", c), 32'(lu_ready),
                      32'(c < 2 || c == 5));
            if (c == 4) check("full_stall", 32'(stall_req), 32'd1);
            tick();
        end
        idle();
        tick();
        tick();

        // write to reg 0 is suppressed
        pipe_we = 1'b1; pipe_dest = 5'd0; pipe_wdata = 32'hDEAD;
        tick();
        idle();
        check("reg0_we", 32'(rf_we), 32'd0);
        tick();

        // LU latency on an idle port
        lu_valid = 1'b1; lu_dest = 5'd3; lu_data = 32'h33;
        expect_wr(5'd3, 32'h33);
        tick();
        lu_valid = 1'b0;
`ifndef WB_BYPASS_EN
        check("lat_first_edge_we", 32'(rf_we), 32'd0);
        tick();
`endif
        check("lat_we", 32'(rf_we), 32'd1);
        check("lat_waddr", 32'(rf_waddr), 32'd3);
        tick();

        // async reset in the middle of traffic
        rd_addr_a = 5'd12;
        check("pre_rst_busy", 32'(busy_a), 32'd1);
        pipe_we = 1'b1; pipe_dest = 5'd7; pipe_wdata = 32'h777;
        lu_valid = 1'b1; lu_dest = 5'd25; lu_data = 32'h2525;
        tick();
        idle();
        check("pre_rst_waddr", 32'(rf_waddr), 32'd7);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_we", 32'(rf_we), 32'd0);
        check("mid_rst_ready", 32'(lu_ready), 32'd1);
        check("mid_rst_busy_a", 32'(busy_a), 32'd0);
        check("mid_rst_busy_b", 32'(busy_b), 32'd0);
        check("mid_rst_stall", 32'(stall_req), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        check("post_rst_we", 32'(rf_we), 32'd0);
        check("post_rst_busy", 32'(busy_a), 32'd0);

        check("drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
